pe_block_quant: RTL and testbench

Parametrised successor to the systolic PE block. It holds a BLOCK_NUM × ARRAY_NUM grid of multiply-accumulate cells with a shared broadcast weight and left-shift operand passing between lanes, and adds signed/unsigned mode and configurable widths. On a drain request it snapshots all accumulators, requantizes them (round, shift, saturate) and streams one block row per beat over a valid/ready port, while the live accumulators keep computing.

---
 rtl/pe_quant_pkg.sv | 51 +++++
 rtl/pe_block_quant_if.sv | 18 +
 rtl/pe_mac_cell.sv | 58 +++++
 rtl/pe_block_quant.sv | 176 +++++++++++++++++
 tb/tb_pe_block_quant.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_quant_pkg.sv
// Shared types and the requantization helper for pe_block_quant.
// The helper works on a wide signed container so any ACC_W/OUT_W up to RQ_W fits.
package pe_quant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SEND
    } state_t;

    localparam int unsigned RQ_W = 64;

    typedef struct packed {
        logic            sat;
        logic [RQ_W-1:0] val;
    } rq_t;

    // acc_ext must already be sign- or zero-extended to RQ_W by the caller.
    function automatic rq_t requant(input logic [RQ_W-1:0] acc_ext,
                                    input logic [7:0]      shift,
                                    input logic            is_signed,
                                    input int unsigned     out_w);
        logic signed [RQ_W-1:0] v;
        logic signed [RQ_W-1:0] hi;
        logic signed [RQ_W-1:0] lo;
        rq_t r;
        v = $signed(acc_ext);
        if (shift != 8'd0) begin
            v = v + $signed(RQ_W'(1) << (shift - 8'd1));
            v = is_signed ? (v >>> shift) : $signed($unsigned(v) >> shift);
        end
        if (is_signed) begin
            hi = $signed((RQ_W'(1) << (out_w - 1)) - RQ_W'(1));
            lo = ~hi;
        end else begin
            hi = $signed((RQ_W'(1) << out_w) - RQ_W'(1));
            lo = '0;
        end
        r.sat = 1'b0;
        r.val = $unsigned(v);
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = $unsigned(hi);
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = $unsigned(lo);
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_block_quant_if.sv
// Output stream of pe_block_quant: one requantized block row per valid/ready beat.
interface pe_block_quant_if #(
    parameter int unsigned ARRAY_NUM = 3,
    parameter int unsigned BLOCK_NUM = 3,
    parameter int unsigned OUT_W     = 8
);
    localparam int unsigned IDX_W = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1;

    logic                       oValid;
    logic [OUT_W*ARRAY_NUM-1:0] oResult;
    logic [IDX_W-1:0]           oBlockIdx;
    logic                       oLast;
    logic                       oSat;
    logic                       iReady;

    modport master (output oValid, oResult, oBlockIdx, oLast, oSat, input iReady);
    modport slave  (input oValid, oResult, oBlockIdx, oLast, oSat, output iReady);
endinterface

// File: rtl/pe_mac_cell.sv
// One grid cell: held operand register, multiplier and accumulator.
// oAccNext is exposed so the top can snapshot the value about to be written.
module pe_mac_cell #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = 24
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iLoad,
    input  logic                iSigned,
    input  logic                iVldD,
    input  logic                iClrD,
    input  logic [DATA_W-1:0]   iOperand,
    input  logic [WEIGHT_W-1:0] iWeightQ,
    output logic [DATA_W-1:0]   oOperand,
    output logic [ACC_W-1:0]    oAccNext
);
    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

    logic [DATA_W-1:0] r_op;
    logic [ACC_W-1:0]  r_acc;
    logic [PROD_W-1:0] w_op_ext;
    logic [PROD_W-1:0] w_wt_ext;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_prod_ext;

    // Extending both factors to the full product width makes one multiplier serve both modes.
    always_comb begin
        w_op_ext   = iSigned ? {{WEIGHT_W{r_op[DATA_W-1]}}, r_op} : {{WEIGHT_W{1'b0}}, r_op};
        w_wt_ext   = iSigned ? {{DATA_W{iWeightQ[WEIGHT_W-1]}}, iWeightQ} : {{DATA_W{1'b0}}, iWeightQ};
        w_prod     = w_op_ext * w_wt_ext;
        w_prod_ext = iSigned ? {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod}
                             : {{(ACC_W-PROD_W){1'b0}}, w_prod};
        if (iClrD) begin
            oAccNext = iVldD ? w_prod_ext : '0;
        end else if (iVldD) begin
            oAccNext = r_acc + w_prod_ext;
        end else begin
            oAccNext = r_acc;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_op  <= '0;
            r_acc <= '0;
        end else begin
            if (iLoad) begin
                r_op <= iOperand;
            end
            r_acc <= oAccNext;
        end
    end

    assign oOperand = r_op;

endmodule

// File: rtl/pe_block_quant.sv
// BLOCK_NUM x ARRAY_NUM MAC grid with snapshot-requantize-stream drain.
// The MAC pipeline runs freely; the FSM only controls the snapshot and output beats.
module pe_block_quant
    import pe_quant_pkg::*;
#(
    parameter int unsigned ARRAY_NUM = 3,
    parameter int unsigned BLOCK_NUM = 3,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WEIGHT_W  = 8,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned SHIFT_W   = 5
) (
    input  logic                                iClk,
    input  logic                                iRst,
    input  logic                                iValid,
    input  logic                                iClearAcc,
    input  logic                                iCfsSigned,
    input  logic [ARRAY_NUM-2:0]                iCfsPassDataLeft,
    input  logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] iData,
    input  logic [WEIGHT_W-1:0]                 iWeight,
    input  logic [SHIFT_W-1:0]                  iCfsOutputShift,
    input  logic                                iDrain,
    pe_block_quant_if.master                    out_if,
    output logic                                oBusy
);
    localparam int unsigned CELLS = BLOCK_NUM * ARRAY_NUM;
    localparam int unsigned IDX_W = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_beat, w_beat_nxt;
    logic [WEIGHT_W-1:0]  r_weight;
    logic                 r_vld_d;
    logic                 r_clr_d;
    logic [DATA_W-1:0]    w_op      [CELLS];
    logic [ACC_W-1:0]     w_acc_nxt [CELLS];
    rq_t                  w_rq      [CELLS];
    logic [OUT_W-1:0]     r_snap    [CELLS];
    logic [BLOCK_NUM-1:0] r_sat;
    logic [BLOCK_NUM-1:0] w_blk_sat;
    logic                 w_send;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_weight <= '0;
            r_vld_d  <= 1'b0;
            r_clr_d  <= 1'b0;
        end else begin
            r_vld_d <= iValid;
            r_clr_d <= iClearAcc;
            if (iValid) begin
                r_weight <= iWeight;
            end
        end
    end

    for (genvar b = 0; b < BLOCK_NUM; b++) begin : g_blk
        for (genvar a = 0; a < ARRAY_NUM; a++) begin : g_lane
            localparam int unsigned IDX = b * ARRAY_NUM + a;
            logic [DATA_W-1:0] w_load;
            logic [RQ_W-1:0]   w_acc_ext;

            // Pass-left reads the neighbour's register before this edge's update.
            if (a == ARRAY_NUM - 1) begin : g_edge
                assign w_load = iData[IDX*DATA_W +: DATA_W];
            end else begin : g_pass
                assign w_load = iCfsPassDataLeft[a] ? w_op[IDX+1] : iData[IDX*DATA_W +: DATA_W];
            end

            pe_mac_cell #(
                .DATA_W   (DATA_W),
                .WEIGHT_W (WEIGHT_W),
                .ACC_W    (ACC_W)
            ) u_cell (
                .iClk     (iClk),
                .iRst     (iRst),
                .iLoad    (iValid),
                .iSigned  (iCfsSigned),
                .iVldD    (r_vld_d),
                .iClrD    (r_clr_d),
                .iOperand (w_load),
                .iWeightQ (r_weight),
                .oOperand (w_op[IDX]),
                .oAccNext (w_acc_nxt[IDX])
            );

            assign w_acc_ext = iCfsSigned ? {{(RQ_W-ACC_W){w_acc_nxt[IDX][ACC_W-1]}}, w_acc_nxt[IDX]}
                                          : {{(RQ_W-ACC_W){1'b0}}, w_acc_nxt[IDX]};
            assign w_rq[IDX] = requant(w_acc_ext, 8'(iCfsOutputShift), iCfsSigned, OUT_W);
        end
    end

    always_comb begin
        w_blk_sat = '0;
        for (int unsigned b = 0; b < BLOCK_NUM; b++) begin
            for (int unsigned a = 0; a < ARRAY_NUM; a++) begin
                w_blk_sat[b] = w_blk_sat[b] | w_rq[b*ARRAY_NUM + a].sat;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        unique case (r_state)
            ST_IDLE: begin
                if (iDrain) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_SEND;
                w_beat_nxt  = '0;
            end
            ST_SEND: begin
                if (out_if.iReady) begin
                    if (r_beat == IDX_W'(BLOCK_NUM - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // Capturing the next accumulator value folds in the MAC issued with iDrain.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int unsigned i = 0; i < CELLS; i++) begin
                r_snap[i] <= '0;
            end
            r_sat <= '0;
        end else if (r_state == ST_FLUSH) begin
            for (int unsigned i = 0; i < CELLS; i++) begin
                r_snap[i] <= w_rq[i].val[OUT_W-1:0];
            end
            r_sat <= w_blk_sat;
        end
    end

    assign w_send = (r_state == ST_SEND);
    assign oBusy  = (r_state != ST_IDLE);

    always_comb begin
        out_if.oValid    = w_send;
        out_if.oResult   = '0;
        out_if.oBlockIdx = '0;
        out_if.oLast     = 1'b0;
        out_if.oSat      = 1'b0;
        if (w_send) begin
            for (int unsigned a = 0; a < ARRAY_NUM; a++) begin
                out_if.oResult[a*OUT_W +: OUT_W] = r_snap[32'(r_beat) * ARRAY_NUM + a];
            end
            out_if.oBlockIdx = r_beat;
            out_if.oLast     = (r_beat == IDX_W'(BLOCK_NUM - 1));
            out_if.oSat      = r_sat[r_beat];
        end
    end

endmodule

// File: tb/tb_pe_block_quant.sv
// Randomized self-checking bench for pe_block_quant against an issue-time arithmetic model.
module tb_pe_block_quant;
    localparam int unsigned A = 3;
    localparam int unsigned B = 3;
    localparam int unsigned N = A * B;

    logic           iClk = 1'b0;
    logic           iRst;
    logic           iValid;
    logic           iClearAcc;
    logic           iCfsSigned;
    logic [A-2:0]   iCfsPassDataLeft;
    logic [8*N-1:0] iData;
    logic [7:0]     iWeight;
    logic [4:0]     iCfsOutputShift;
    logic           iDrain;
    logic           oBusy;

    pe_block_quant_if #(.ARRAY_NUM(A), .BLOCK_NUM(B), .OUT_W(8)) bus ();

    pe_block_quant #(
        .ARRAY_NUM (A),
        .BLOCK_NUM (B),
        .DATA_W    (8),
        .WEIGHT_W  (8),
        .ACC_W     (24),
        .OUT_W     (8),
        .SHIFT_W   (5)
    ) dut (
        .iClk             (iClk),
        .iRst             (iRst),
        .iValid           (iValid),
        .iClearAcc        (iClearAcc),
        .iCfsSigned       (iCfsSigned),
        .iCfsPassDataLeft (iCfsPassDataLeft),
        .iData            (iData),
        .iWeight          (iWeight),
        .iCfsOutputShift  (iCfsOutputShift),
        .iDrain           (iDrain),
        .out_if           (bus),
        .oBusy            (oBusy)
    );

    always #5 iClk = ~iClk;

    // Reference model state: operands and accumulators updated at issue time.
    logic [7:0] m_op  [N];
    longint     m_acc [N];
    bit         m_sg;
    int         m_sh;
    bit         m_busy;
    int         exp_res [N];
    bit         exp_sat [B];
    int         got_res [N];
    int         got_sat [B];
    int         n_pass;
    int         n_total;
    logic [7:0] zero_d [N];

    task automatic check(input string tag, input longint got, input longint expv);
        n_total++;
        if (got == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic longint mul(input logic [7:0] o, input logic [7:0] w, input bit sg);
        if (sg) return longint'($signed(o)) * longint'($signed(w));
        return longint'(o) * longint'(w);
    endfunction

    function automatic void take_snapshot();
        for (int b = 0; b < B; b++) exp_sat[b] = 1'b0;
        for (int i = 0; i < N; i++) begin
            longint v;
            longint lo;
            longint hi;
            int     r;
            bit     s;
            v = m_acc[i];
            if (m_sg && m_acc[i][23]) v = v - (longint'(1) << 24);
            if (m_sh > 0) v = (v + (longint'(1) << (m_sh - 1))) >>> m_sh;
            lo = m_sg ? -128 : 0;
            hi = m_sg ? 127 : 255;
            s  = 1'b0;
            if (v > hi) begin v = hi; s = 1'b1; end
            if (v < lo) begin v = lo; s = 1'b1; end
            r = int'(v) & 255;
            exp_res[i] = r;
            exp_sat[i / A] = exp_sat[i / A] | s;
        end
    endfunction

    task automatic drive(input bit v, input bit c, input logic [A-2:0] p,
                         input logic [7:0] d [N], input logic [7:0] w, input bit dr);
        logic [7:0] nop [N];
        iValid           = v;
        iClearAcc        = c;
        iCfsPassDataLeft = p;
        iWeight          = w;
        iDrain           = dr;
        for (int i = 0; i < N; i++) iData[i*8 +: 8] = d[i];
        nop = m_op;
        if (v) begin
            for (int b = 0; b < B; b++) begin
                for (int a = 0; a < A; a++) begin
                    if (a == A - 1) nop[b*A+a] = d[b*A+a];
                    else if (p[a]) nop[b*A+a] = m_op[b*A+a+1];
                    else nop[b*A+a] = d[b*A+a];
                end
            end
        end
        m_op = nop;
        for (int i = 0; i < N; i++) begin
            longint pr;
            pr = v ? mul(m_op[i], w, m_sg) : 0;
            if (c) m_acc[i] = pr;
            else if (v) m_acc[i] = m_acc[i] + pr;
            m_acc[i] = m_acc[i] & longint'(24'hFFFFFF);
        end
        if (dr && !m_busy) begin
            m_busy = 1'b1;
            take_snapshot();
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, zero_d, 8'd0, 1'b0);
    endtask

    task automatic rand_mac(input bit first, input bit dr);
        logic [7:0] d [N];
        for (int i = 0; i < N; i++) d[i] = 8'($urandom);
        drive(first || ($urandom_range(0, 4) != 0), first || ($urandom_range(0, 9) == 0),
              (A-1)'($urandom), d, 8'($urandom), dr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_op[i]  = '0;
            m_acc[i] = 0;
        end
        m_busy = 1'b0;
    endtask

    task automatic set_mode(input bit sg);
        idle();
        tick();
        iCfsSigned = sg;
        m_sg       = sg;
    endtask

    task automatic set_shift(input int sh);
        iCfsOutputShift = 5'(sh);
        m_sh            = sh;
    endtask

    // Called one sample after the edge that accepted iDrain (FSM in FLUSH).
    task automatic run_drain(input int stall_beat, input bit mac_during, input bit drain_during);
        int k = 0;
        int stall = 0;
        int cyc = 0;
        check("flush_busy", oBusy, 1);
        check("flush_valid", bus.oValid, 0);
        if (mac_during) rand_mac(1'b0, 1'b0);
        else idle();
        tick();
        while (k < B && cyc < 60) begin
            cyc++;
            check("beat_valid", bus.oValid, 1);
            check("beat_idx", bus.oBlockIdx, k);
            check("beat_last", bus.oLast, (k == B - 1));
            check("beat_sat", bus.oSat, exp_sat[k]);
            for (int a = 0; a < A; a++) begin
                check("beat_lane", bus.oResult[a*8 +: 8], exp_res[k*A+a]);
                got_res[k*A+a] = int'(bus.oResult[a*8 +: 8]);
            end
            got_sat[k] = int'(bus.oSat);
            check("beat_busy", oBusy, 1);
            if (k == stall_beat && stall < 3) begin
                bus.iReady = 1'b0;
                stall++;
            end else begin
                bus.iReady = ($urandom_range(0, 3) != 0);
            end
            if (mac_during) rand_mac(1'b0, drain_during && ($urandom_range(0, 1) == 1));
            else drive(1'b0, 1'b0, '0, zero_d, 8'd0, drain_during);
            if (bus.iReady) k++;
            tick();
        end
        if (k < B) check("drain_timeout", k, B);
        bus.iReady = 1'b0;
        m_busy     = 1'b0;
        idle();
        check("post_busy", oBusy, 0);
        check("post_valid", bus.oValid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d [N];
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < N; i++) zero_d[i] = '0;
        iRst       = 1'b1;
        bus.iReady = 1'b0;
        iCfsSigned = 1'b0;
        m_sg       = 1'b0;
        set_shift(0);
        model_reset();
        idle();
        repeat (3) tick();
        check("rst_valid", bus.oValid, 0);
        check("rst_result", bus.oResult, 0);
        check("rst_idx", bus.oBlockIdx, 0);
        check("rst_last", bus.oLast, 0);
        check("rst_sat", bus.oSat, 0);
        check("rst_busy", oBusy, 0);
        iRst = 1'b0;

        // Drain with nothing accumulated.
        drive(1'b0, 1'b0, '0, zero_d, 8'd0, 1'b1);
        tick();
        run_drain(-1, 1'b0, 1'b0);

        // Basic unsigned MAC, last product issued together with iDrain.
        d = zero_d; d[0] = 8'd1;
        drive(1'b1, 1'b1, '0, d, 8'd1, 1'b0); tick();
        d[0] = 8'd2;
        drive(1'b1, 1'b0, '0, d, 8'd2, 1'b0); tick();
        d[0] = 8'd3;
        drive(1'b1, 1'b0, '0, d, 8'd3, 1'b1); tick();
        run_drain(1, 1'b0, 1'b0);
        check("basic_b0l0", got_res[0], 14);
        check("basic_b0l1", got_res[1], 0);

        // Pass-left.
        d = zero_d; d[1] = 8'd6;
        drive(1'b1, 1'b1, 2'b00, d, 8'd2, 1'b0); tick();
        d[1] = 8'd7;
        drive(1'b1, 1'b0, 2'b01, d, 8'd3, 1'b1); tick();
        run_drain(-1, 1'b0, 1'b0);
        check("pass_b0l0", got_res[0], 18);
        check("pass_b0l1", got_res[1], 33);

        // Signed saturation.
        set_mode(1'b1);
        set_shift(7);
        d = zero_d; d[0] = 8'h80;
        drive(1'b1, 1'b1, '0, d, 8'd127, 1'b0); tick();
        drive(1'b1, 1'b0, '0, d, 8'd127, 1'b1); tick();
        run_drain(0, 1'b0, 1'b0);
        check("sgn_clamp", got_res[0], 128);
        check("sgn_sat", got_sat[0], 1);

        // Unsigned rounding without saturation.
        set_mode(1'b0);
        set_shift(8);
        d = zero_d; d[5] = 8'd255;
        drive(1'b1, 1'b1, '0, d, 8'd255, 1'b0); tick();
        drive(1'b0, 1'b0, '0, zero_d, 8'd0, 1'b1); tick();
        run_drain(-1, 1'b0, 1'b0);
        check("uns_round", got_res[5], 254);
        check("uns_sat", got_sat[1], 0);

        // Clear with valid discards prior accumulation.
        set_shift(0);
        repeat (3) begin rand_mac(1'b0, 1'b0); tick(); end
        d = zero_d; d[7] = 8'd5;
        drive(1'b1, 1'b1, '0, d, 8'd9, 1'b1); tick();
        run_drain(2, 1'b0, 1'b0);
        check("clr_b2l1", got_res[7], 45);
        check("clr_other", got_res[5], 0);

        // Overlap: MACs and ignored drains while sending, then a second drain.
        set_shift(4);
        rand_mac(1'b1, 1'b1); tick();
        run_drain(1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, zero_d, 8'd0, 1'b1); tick();
        run_drain(-1, 1'b0, 1'b0);

        // Reset during SEND.
        rand_mac(1'b1, 1'b1); tick();
        idle(); tick();
        check("pre_rst_valid", bus.oValid, 1);
        iRst = 1'b1;
        idle();
        tick();
        check("midrst_valid", bus.oValid, 0);
        check("midrst_busy", oBusy, 0);
        iRst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, '0, zero_d, 8'd0, 1'b1); tick();
        run_drain(-1, 1'b0, 1'b0);
        check("midrst_zero", got_res[0], 0);

        // Randomized rounds in both modes.
        for (int r = 0; r < 12; r++) begin
            if (r % 3 == 0) set_mode(((r / 3) % 2) == 1);
            set_shift($urandom_range(0, 12));
            rand_mac(1'b1, 1'b0); tick();
            repeat ($urandom_range(1, 5)) begin rand_mac(1'b0, 1'b0); tick(); end
            rand_mac(1'b0, 1'b1); tick();
            run_drain($urandom_range(0, 2), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
